// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues word-aligned loads/stores over a req/ack port,
// stalls the pipeline until completion, and flags misaligned or timed-out accesses.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic [4:0]  RdAddr_i,
  output logic [31:0] alu_o,
  output logic [31:0] rdata_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [4:0]  RdAddr_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic w_idle;
  logic w_busy;
  logic w_access;
  logic w_aligned;
  logic w_start;
  logic w_misal;
  logic w_ack;
  logic w_tmo;
  logic w_stall;

  assign w_idle    = (r_state == S_IDLE);
  assign w_busy    = (r_state == S_BUSY);
  assign w_access  = MemRead_i | MemWrite_i;
  assign w_aligned = (addr_i[1:0] == 2'b00);
  assign w_start   = w_idle & w_access & w_aligned;
  assign w_misal   = w_idle & w_access & ~w_aligned;
  // ack has priority over a timeout landing in the same cycle
  assign w_ack     = w_busy & mem_ack_i;
  assign w_tmo     = w_busy & ~mem_ack_i & (r_cnt == CNT_LAST);
  assign w_stall   = w_start | w_busy;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_BUSY;
            r_cnt   <= 8'd0;
            r_req   <= 1'b1;
            r_we    <= MemWrite_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
          end else if (w_misal) begin
            r_err <= 1'b1;
          end
        end
        S_BUSY: begin
          if (w_ack) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            if (!r_we) r_rdata <= mem_rdata_i;
          end else if (w_tmo) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            if (!r_we) r_rdata <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign alu_o       = addr_i;
  assign rdata_o     = r_rdata;
  assign MemtoReg_o  = MemtoReg_i;
  assign RdAddr_o    = RdAddr_i;
  assign RegWrite_o  = RegWrite_i & ~w_stall & ~w_misal;
  assign stall_o     = w_stall;
  assign err_o       = r_err;
  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

MEM-stage controller between the EX/MEM pipeline register and the MEM/WB pipeline register. It runs word-aligned loads and stores against a variable-latency data memory over a req/ack handshake and stalls the pipeline until the access completes. It feeds MEM/WB with the ALU result, the loaded word and the WB control bits, and converts misaligned or timed-out accesses into a sticky error.

## Interface
Parameters:
- TIMEOUT, 16, max BUSY cycles without mem_ack_i before the access is abandoned; legal range 1..255.

Ports:
- clk_i  in  1  pipeline clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- MemRead_i  in  1  load request from EX/MEM.
- MemWrite_i  in  1  store request from EX/MEM.
- addr_i  in  32  ALU result / effective address from EX/MEM.
- wdata_i  in  32  store data from EX/MEM.
- RegWrite_i  in  1  WB control from EX/MEM.
- MemtoReg_i  in  1  WB control from EX/MEM.
- RdAddr_i  in  5  destination register from EX/MEM.
- alu_o  out  32  to MEM/WB mux input 0; equals addr_i.
- rdata_o  out  32  to MEM/WB mux input 1; captured load data.
- RegWrite_o  out  1  to MEM/WB; RegWrite_i gated (see Operation).
- MemtoReg_o  out  1  to MEM/WB; equals MemtoReg_i.
- RdAddr_o  out  5  to MEM/WB; equals RdAddr_i.
- stall_o  out  1  hold PC/IF/ID/EX/EX-MEM when 1.
- err_o  out  1  sticky error flag.
- mem_req_o  out  1  memory request, registered.
- mem_we_o  out  1  1 = write, registered.
- mem_addr_o  out  32  registered address.
- mem_wdata_o  out  32  registered store data.
- mem_ack_i  in  1  memory completion, one-cycle pulse.
- mem_rdata_i  in  32  read data, valid when mem_ack_i=1.

## Operation
- Access = MemRead_i | MemWrite_i. If both are 1, it is a write and rdata_o is not updated.
- FSM states are IDLE, BUSY and DONE.
- IDLE, no access: stall_o=0 and all passthroughs are live.
- IDLE, aligned access (addr_i[1:0]==0): stall_o=1 combinationally in the same cycle. Next state is BUSY. mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o load on that edge. The TIMEOUT counter clears to 0.
- IDLE, misaligned access: no request is issued and stall_o=0. err_o sets on the next edge. RegWrite_o=0 this cycle. The FSM stays in IDLE.
- BUSY: stall_o=1 and mem_req_o is held at 1 with stable addr/we/wdata. mem_ack_i=1 captures mem_rdata_i into rdata_o if the access is a read, and moves the FSM to DONE. Otherwise the counter increments. When the counter reaches TIMEOUT-1 without an ack, the FSM moves to DONE, rdata_o loads 0 and err_o sets.
- Ack and timeout in the same cycle: ack wins and err_o is not set.
- DONE: stall_o=0 and mem_req_o=0, so MEM/WB latches this instruction at the end of DONE. Next state is IDLE unconditionally.
- RegWrite_o = RegWrite_i & ~stall_o & ~misaligned, which inserts a bubble into MEM/WB during stalls.
- mem_ack_i is ignored outside BUSY.
- err_o clears only on rst_i.

## Timing
- Reset values: state IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0, err_o=0, counter=0.
- Combinational outputs follow inputs after reset: stall_o=0 while no access is presented; alu_o, MemtoReg_o and RdAddr_o track their inputs; RegWrite_o follows the gating rule.
- Access presented in cycle T with ack in cycle T+k (k≥1): mem_req_o=1 in cycles T+1..T+k. stall_o=1 in T..T+k. DONE occurs in T+k+1. Total stall is k+1 cycles.
- Timeout: BUSY occupies T+1..T+TIMEOUT, then DONE with err_o=1 from T+TIMEOUT+1.
- Back-to-back accesses: the next EX/MEM instruction is seen in IDLE at T+k+2. There is no request overlap.
- rst_i asserted in BUSY: state returns to IDLE and mem_req_o=0 on that edge. The memory must tolerate an abandoned request.
- A non-memory instruction passes in one cycle with no stall.

## Test plan
- Reset, then idle ALU op (RegWrite_i=1, addr_i=0x10) -> stall_o=0, RegWrite_o=1, alu_o=0x10, mem_req_o=0.
- Load at addr_i=0x40, ack 3 cycles after req with mem_rdata_i=0xCAFEF00D -> mem_req_o high for 3 cycles, stall_o high for 4 cycles, rdata_o=0xCAFEF00D in DONE, RegWrite_o=0 until DONE.
- Store at 0x44 with wdata 0x12345678, ack after 1 cycle -> mem_we_o=1, mem_wdata_o=0x12345678, 2 stall cycles, rdata_o unchanged.
- Load at 0x42 (misaligned) -> no mem_req_o, stall_o=0, RegWrite_o=0, err_o=1 next cycle and remains 1.
- TIMEOUT=4, load with no ack -> 4 BUSY cycles, then DONE with rdata_o=0 and err_o=1. Repeat with ack on the 4th BUSY cycle -> err_o stays 0.
- rst_i in the 2nd BUSY cycle -> next cycle IDLE, mem_req_o=0, stall_o=0, err_o=0.
